// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: debounced pedestrian button to single-cycle pass pulses with cooldown and pending request
module ped_request_ctrl #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int COOLDOWN_CYC = 2048,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             en,
  output logic             pass,
  output logic             pending,
  output logic             locked,
  output logic [CNT_W-1:0] press_cnt
);
  localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int CW = $clog2(COOLDOWN_CYC);
  typedef enum logic [1:0] {S_IDLE, S_DEB, S_REL} state_t;
  state_t state;
  logic s1, btn_s, valid, fire;
  logic [DW-1:0] db_cnt;
  logic [CW-1:0] cd_cnt;
  // the S_IDLE cycle that first sees btn_s high counts as one of the stable cycles
  always_comb begin
    valid = en && state == S_DEB && btn_s && db_cnt == DW'(DEBOUNCE_CYC - 2);
    fire  = en && (valid || pending) && cd_cnt == '0;
  end
  assign locked = cd_cnt != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      btn_s     <= 1'b0;
      state     <= S_IDLE;
      db_cnt    <= '0;
      cd_cnt    <= '0;
      pass      <= 1'b0;
      pending   <= 1'b0;
      press_cnt <= '0;
    end else begin
      s1      <= btn;
      btn_s   <= s1;
      pass    <= fire;
      pending <= en && !fire && (pending || valid);
      cd_cnt  <= fire ? CW'(COOLDOWN_CYC - 1) : locked ? cd_cnt - CW'(1) : cd_cnt;
      if (fire && press_cnt != {CNT_W{1'b1}})
        press_cnt <= press_cnt + CNT_W'(1);
      if (!en) begin
        state  <= S_IDLE;
        db_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state  <= btn_s ? S_DEB : S_IDLE;
            db_cnt <= '0;
          end
          S_DEB: begin
            state  <= !btn_s ? S_IDLE : valid ? S_REL : S_DEB;
            db_cnt <= (!btn_s || valid) ? '0 : db_cnt + DW'(1);
          end
          S_REL: begin
            state  <= (!btn_s && db_cnt == DW'(DEBOUNCE_CYC - 1)) ? S_IDLE : S_REL;
            db_cnt <= (btn_s || db_cnt == DW'(DEBOUNCE_CYC - 1)) ? '0 : db_cnt + DW'(1);
          end
          default: begin
            state  <= S_IDLE;
            db_cnt <= '0;
          end
        endcase
      end
    end
  end
endmodule
